// File: rtl/pump_ctrl.sv
// Tank pump controller: hysteresis start/stop on a strobed level, with minimum
// on-time, post-stop lockout, dry-run fault detection and level alarms.
module pump_ctrl #(
  parameter int unsigned LOW_TH      = 64,
  parameter int unsigned HIGH_TH     = 192,
  parameter int unsigned MIN_ON      = 1000,
  parameter int unsigned MIN_OFF     = 1000,
  parameter int unsigned DRY_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] level,
  input  logic       level_valid,
  input  logic       en,
  input  logic       fault_clr,
  output logic       pump,
  output logic       fault,
  output logic [1:0] state,
  output logic       alarm_low,
  output logic       alarm_high
);

  localparam int unsigned LW = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned XW = CW + 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_RUN   = 2'b01,
    ST_LOCK  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] ref_q, ref_d;
  logic [CW-1:0] on_q, on_d;
  logic [CW-1:0] dry_q, dry_d;
  logic [CW-1:0] off_q, off_d;
  logic          rise, low_hit, high_hit, on_done, dry_last, off_last;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  // Next-state and counter logic; lvl_d doubles as the compared level.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    on_d    = on_q;
    dry_d   = dry_q;
    off_d   = off_q;
    lvl_d   = level_valid ? level : lvl_q;

    rise     = level_valid && (level > ref_q);
    low_hit  = level_valid && (CW'(level) <= LOW_TH);
    high_hit = CW'(lvl_d) >= HIGH_TH;
    on_done  = on_q >= MIN_ON;
    dry_last = (XW'(dry_q) + XW'(1)) >= XW'(DRY_TIMEOUT);
    off_last = (XW'(off_q) + XW'(1)) >= XW'(MIN_OFF);

    case (state_q)
      ST_OFF: begin
        if (en && low_hit) begin
          state_d = ST_RUN;
          on_d    = '0;
          dry_d   = '0;
          ref_d   = level;
        end
      end
      ST_RUN: begin
        on_d = on_done ? on_q : sat_inc(on_q);
        if (rise) begin
          ref_d = level;
          dry_d = '0;
        end else begin
          dry_d = sat_inc(dry_q);
        end
        // Enable loss beats a dry fault, which beats a normal high-level stop.
        if (!en) begin
          state_d = ST_LOCK;
          off_d   = '0;
        end else if (!rise && dry_last) begin
          state_d = ST_FAULT;
        end else if (high_hit && on_done) begin
          state_d = ST_LOCK;
          off_d   = '0;
        end
      end
      ST_LOCK: begin
        off_d = sat_inc(off_q);
        if (off_last) begin
          state_d = ST_OFF;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_LOCK;
          off_d   = '0;
        end
      end
    endcase
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      lvl_q      <= '0;
      ref_q      <= '0;
      on_q       <= '0;
      dry_q      <= '0;
      off_q      <= '0;
      pump       <= 1'b0;
      fault      <= 1'b0;
      state      <= 2'b00;
      alarm_low  <= 1'b1;
      alarm_high <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      ref_q      <= ref_d;
      on_q       <= on_d;
      dry_q      <= dry_d;
      off_q      <= off_d;
      pump       <= (state_d == ST_RUN);
      fault      <= (state_d == ST_FAULT);
      state      <= state_d;
      alarm_low  <= (lvl_d == '0);
      alarm_high <= (lvl_d == '1);
    end
  end

endmodule

// File: tb/tb_pump_ctrl.sv
// Bench for pump_ctrl: directed scenarios then randomized traffic, all checked
// against a mode/age reference model of the controller's behaviour.
module tb_pump_ctrl;

  localparam int LOW_TH  = 64;
  localparam int HIGH_TH = 192;
  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;
  localparam int DRY_TO  = 10;

  localparam int M_OFF = 0, M_RUN = 1, M_LOCK = 2, M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] level;
  logic       level_valid;
  logic       en;
  logic       fault_clr;
  logic       pump;
  logic       fault;
  logic [1:0] state;
  logic       alarm_low;
  logic       alarm_high;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: current mode, cycles spent in it, last seen level,
  // highest level since pumping began, cycles since that level last rose.
  int m_mode  = M_OFF;
  int m_age   = 0;
  int m_lvl   = 0;
  int m_peak  = 0;
  int m_since = 0;

  pump_ctrl #(
    .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .MIN_ON(MIN_ON),
    .MIN_OFF(MIN_OFF), .DRY_TIMEOUT(DRY_TO)
  ) dut (
    .clk(clk), .rst(rst), .level(level), .level_valid(level_valid),
    .en(en), .fault_clr(fault_clr), .pump(pump), .fault(fault),
    .state(state), .alarm_low(alarm_low), .alarm_high(alarm_high)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    int  cmp;
    int  nxt;
    bit  up;
    if (rst) begin
      m_mode = M_OFF; m_age = 0; m_lvl = 0; m_peak = 0; m_since = 0;
      return;
    end
    cmp = level_valid ? int'(level) : m_lvl;
    nxt = m_mode;
    case (m_mode)
      M_OFF: if (en && level_valid && int'(level) <= LOW_TH) begin
        nxt = M_RUN; m_peak = int'(level); m_since = 0;
      end
      M_RUN: begin
        up = level_valid && int'(level) > m_peak;
        if (!en) nxt = M_LOCK;
        else if (!up && m_since >= DRY_TO - 1) nxt = M_FAULT;
        else if (cmp >= HIGH_TH && m_age >= MIN_ON) nxt = M_LOCK;
        if (up) begin m_peak = int'(level); m_since = 0; end
        else m_since++;
      end
      M_LOCK: if (m_age >= MIN_OFF - 1) nxt = M_OFF;
      default: if (fault_clr) nxt = M_LOCK;
    endcase
    m_age  = (nxt != m_mode) ? 0 : m_age + 1;
    m_mode = nxt;
    if (level_valid) m_lvl = int'(level);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("state", 32'(state), 32'(m_mode));
    check("pump", 32'(pump), 32'(m_mode == M_RUN));
    check("fault", 32'(fault), 32'(m_mode == M_FAULT));
    check("alarm_low", 32'(alarm_low), 32'(m_lvl == 0));
    check("alarm_high", 32'(alarm_high), 32'(m_lvl == 255));
  endtask

  task automatic drive(input logic v, input logic [7:0] l, input logic e, input logic c);
    level_valid = v; level = l; en = e; fault_clr = c;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int r;
    rst = 1'b1;
    drive(0, 8'd0, 0, 0);
    ticks(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_alarm_low", 32'(alarm_low), 32'd1);
    rst = 1'b0;

    // Start-up, then enable drop with lockout ignoring a low strobe.
    drive(1, 8'd60, 1, 0); tick();
    check("start_state", 32'(state), 32'd1);
    check("start_pump", 32'(pump), 32'd1);
    drive(1, 8'd70, 1, 0); tick();
    check("still_run", 32'(state), 32'd1);
    drive(0, 8'd0, 0, 0); tick();
    check("en_drop_lock", 32'(state), 32'd2);
    drive(1, 8'd10, 1, 0); tick();
    check("lock_ignore", 32'(state), 32'd2);
    drive(0, 8'd0, 1, 0); ticks(2);
    check("lock_to_off", 32'(state), 32'd0);

    // Minimum on-time before a high-level stop.
    drive(1, 8'd60, 1, 0); tick();
    drive(0, 8'd0, 1, 0); tick();
    drive(1, 8'd200, 1, 0); tick();
    check("minon_hold", 32'(state), 32'd1);
    drive(0, 8'd0, 1, 0); ticks(2);
    drive(1, 8'd200, 1, 0); tick();
    check("minon_stop", 32'(state), 32'd2);
    check("minon_pump", 32'(pump), 32'd0);
    drive(0, 8'd0, 1, 0); ticks(2);
    check("minon_lock", 32'(state), 32'd2);
    tick();
    check("minon_off", 32'(state), 32'd0);

    // Dry run into FAULT, held until acknowledged.
    drive(1, 8'd50, 1, 0); tick();
    drive(0, 8'd0, 1, 0); ticks(9);
    check("dry_pre", 32'(state), 32'd1);
    tick();
    check("dry_fault", 32'(state), 32'd3);
    check("dry_fault_o", 32'(fault), 32'd1);
    ticks(2);
    drive(0, 8'd0, 1, 1); tick();
    check("clr_lock", 32'(state), 32'd2);
    drive(0, 8'd0, 1, 0); ticks(3);
    check("clr_off", 32'(state), 32'd0);

    // Rise on the last dry cycle wins and restarts the dry count.
    drive(1, 8'd50, 1, 0); tick();
    drive(0, 8'd0, 1, 0); ticks(9);
    drive(1, 8'd51, 1, 0); tick();
    check("rise_wins", 32'(state), 32'd1);
    drive(0, 8'd0, 1, 0); ticks(9);
    check("rise_restart", 32'(state), 32'd1);
    tick();
    check("rise_fault", 32'(state), 32'd3);
    drive(0, 8'd0, 1, 1); tick();
    drive(0, 8'd0, 1, 0); ticks(3);

    // Reset mid-RUN, then alarm extremes.
    drive(1, 8'd30, 1, 0); ticks(2);
    check("pre_rst_run", 32'(state), 32'd1);
    rst = 1'b1; drive(0, 8'd0, 1, 0); tick(); rst = 1'b0;
    check("mid_rst_pump", 32'(pump), 32'd0);
    check("mid_rst_alarm", 32'(alarm_low), 32'd1);
    drive(1, 8'd255, 0, 0); tick();
    check("alarm_high", 32'(alarm_high), 32'd1);
    drive(1, 8'd0, 0, 0); tick();
    check("alarm_low", 32'(alarm_low), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 3));
      level_valid = ($urandom_range(0, 2) == 0);
      case (r)
        0: level = 8'($urandom_range(0, 80));
        1: level = 8'($urandom_range(170, 255));
        2: level = 8'($urandom_range(0, 255));
        default: level = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
      endcase
      en        = ($urandom_range(0, 15) != 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pump_ctrl.md
PUMP_CTRL -- requirements
Module: pump_ctrl

Interface
REQ-001 Parameter LOW_TH, default 64, SHALL be the start-pumping level: pump starts at level <= LOW_TH.
REQ-002 Parameter HIGH_TH, default 192, SHALL be the stop-pumping level: pump stops at level >= HIGH_TH; LOW_TH < HIGH_TH is required.
REQ-003 Parameter MIN_ON, default 1000, SHALL be the minimum pump run time in clk cycles before a high-level stop.
REQ-004 Parameter MIN_OFF, default 1000, SHALL be the lockout time in clk cycles after any pump stop.
REQ-005 Parameter DRY_TIMEOUT, default 50000, SHALL be the maximum clk cycles allowed in RUN without a level increase.
REQ-006 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-007 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-008 level  in  8  SHALL be the tank level count from the up/down level counter (0..255).
REQ-009 level_valid  in  1  SHALL be a one-cycle strobe qualifying level.
REQ-010 en  in  1  SHALL be the system enable; low forces the pump off.
REQ-011 fault_clr  in  1  SHALL be the operator fault acknowledge (level-sensitive, sampled per cycle).
REQ-012 pump  out  1  SHALL be the pump drive, high only in RUN.
REQ-013 fault  out  1  SHALL be high only in FAULT.
REQ-014 state  out  2  SHALL expose the FSM state: OFF=00, RUN=01, LOCK=10, FAULT=11.
REQ-015 alarm_low / alarm_high  out  1 each  SHALL flag latched level == 0 and latched level == 255 respectively.

Function
REQ-016 An internal register lvl_q SHALL load level on every cycle with level_valid=1; all comparisons SHALL use the incoming level when level_valid=1, else lvl_q.
REQ-017 pump, fault and state SHALL be decoded from the state register only; pump rises in the first cycle after the qualifying clock edge (1-cycle latency).
REQ-018 OFF: if en=1 and a qualified level <= LOW_TH, the FSM SHALL enter RUN; otherwise it SHALL remain in OFF.
REQ-019 On entering RUN, on_cnt and dry_cnt SHALL clear and ref_lvl SHALL load the current compared level.
REQ-020 RUN: on_cnt SHALL count up each cycle and saturate at MIN_ON.
REQ-021 RUN: en=0 SHALL enter LOCK on the next edge regardless of on_cnt.
REQ-022 RUN: a compared level >= HIGH_TH with on_cnt == MIN_ON SHALL enter LOCK; before on_cnt reaches MIN_ON the FSM SHALL stay in RUN.
REQ-023 RUN: a qualified level > ref_lvl SHALL reload ref_lvl with that level and clear dry_cnt; otherwise dry_cnt SHALL increment.
REQ-024 RUN: when dry_cnt reaches DRY_TIMEOUT-1 with no increase in that cycle, the FSM SHALL enter FAULT; a same-cycle increase SHALL win and prevent the fault.
REQ-025 RUN priority SHALL be en=0, then dry fault, then high-level stop.
REQ-026 LOCK: off_cnt SHALL clear on entry, count each cycle, and leave to OFF after MIN_OFF cycles in LOCK; level and en are ignored during LOCK.
REQ-027 FAULT: the FSM SHALL hold until fault_clr=1, then enter LOCK; fault_clr in any other state SHALL be ignored.
REQ-028 All counters SHALL be 32-bit, SHALL saturate, and SHALL never wrap.
REQ-029 Illegal or unreachable state encodings SHALL not occur; with four 2-bit states every encoding is defined.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL enter OFF with pump=0, fault=0, state=00, lvl_q=0, ref_lvl=0 and all counters at 0.
REQ-031 Because lvl_q resets to 0, alarm_low SHALL be 1 and alarm_high SHALL be 0 after reset.
REQ-032 rst SHALL override every other input, including mid-RUN and in FAULT, where pump and fault drop on the next edge.

Verification (LOW_TH=64, HIGH_TH=192, MIN_ON=4, MIN_OFF=3, DRY_TIMEOUT=10)
REQ-033 Start-up: reset, en=1, strobe level=60 -> state=01 and pump=1 one cycle later; strobe level=70 -> still RUN.
REQ-034 Min-on: in RUN, strobe 200 on the 2nd RUN cycle, strobe 200 again on the 5th -> stay in RUN after the 1st strobe, LOCK after the 2nd; pump=0; OFF 3 cycles later.
REQ-035 Dry run: enter RUN at 50, strobe no increases -> FAULT on the 10th cycle (fault=1, pump=0); fault_clr=1 -> LOCK, then OFF after 3 cycles.
REQ-036 Same-cycle increase: in RUN, strobe 51 exactly in the cycle dry_cnt=9 -> no FAULT, dry_cnt restarts at 0.
REQ-037 Enable drop: in RUN with on_cnt=1, drop en=0 -> LOCK on the next edge; in LOCK, strobe level=10 with en=1 -> ignored until OFF.
REQ-038 Reset mid-RUN: rst=1 for one cycle -> state=00, pump=0, alarm_low=1 on the next edge.
